bracket_scanner: RTL
====================

// Module: bracket_scanner
// PURPOSE
//  Completes a taken branch. The state unit moves the core into CACHE_LOAD_S; this block then scans
//  instruction memory for the matching bracket, reports target_pc, and hands control back via CORE_S.
//  Sits between the state unit and the instruction-memory port; owns that port while scanning.
// PARAMETERS
//  ADDR_W   16  instruction address width
//  DEPTH_W  8   nesting-depth counter width (max depth 2**DEPTH_W-1)
//  SCAN_MAX 4096 fetch budget per scan (used only with SCAN_LIMIT_EN)
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst_n      in   1       reset, asynchronous assert, active-low
//  state_in   in   STATE   current processor state
//  start_pc   in   ADDR_W  pc of bracket that triggered the branch (sampled at start)
//  dir_back   in   1       0: forward scan for ']' ; 1: backward scan for '[' (sampled at start)
//  imem_req   out  1       fetch request, held until imem_ack
//  imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
//  imem_ack   in   1       fetch complete; imem_data valid this cycle
//  imem_data  in   BYTE    fetched opcode
//  state_out  out  STATE   CACHE_LOAD_S while scanning, CORE_S on completion, else state_in
//  target_pc  out  ADDR_W  address of matching bracket, valid with done
//  done       out  1       1-cycle pulse: match found
//  err        out  1       sticky fault flag: unmatched bracket / depth overflow / budget exhausted
// BEHAVIOUR
//  Reset: FSM=IDLE, imem_req=0, imem_addr=0, target_pc=0, done=0, err=0, depth=0, state_out=CORE_S.
//  FSM states: IDLE -> FETCH -> (FETCH | DONE | FAULT); DONE -> IDLE; FAULT -> IDLE.
//  IDLE: state_out=state_in (registered, 1 cycle). On state_in==CACHE_LOAD_S: latch dir_back,
//   depth<=1, pc<=start_pc+1 (fwd) or start_pc-1 (back), go FETCH. Overflow/underflow of that step -> FAULT.
//  FETCH: imem_req=1, imem_addr=pc, state_out=CACHE_LOAD_S. Ack may arrive the cycle req rises.
//   On ack: OPEN=8'h5B, CLOSE=8'h5D. fwd: OPEN depth+1, CLOSE depth-1; back: CLOSE depth+1, OPEN depth-1.
//   Other opcodes: depth unchanged. New depth==0 -> target_pc<=pc, DONE. Else step pc, stay FETCH
//   (req deasserts for one cycle between fetches; back-to-back not required).
//  DONE: done=1, state_out=CORE_S for exactly one cycle, then IDLE.
//  FAULT: err<=1 (sticky until rst_n), state_out=CORE_S one cycle, target_pc unchanged, then IDLE.
//   Causes: depth increment at all-ones; pc step wrapping past 0 or 2**ADDR_W-1.
//  Abort: state_in leaves CACHE_LOAD_S while in FETCH -> IDLE next cycle, req dropped, no done/err.
//  Ack with req=0 ignored. Async reset mid-scan: req drops immediately, all registers to reset values.
//  Latency: trigger to done = 1 + sum(fetch cycles) + 1.
// CONFIGURATION
//  SCAN_LIMIT_EN defined: 12-bit-min fetch counter; the SCAN_MAX-th ack without a match -> FAULT.
//  SCAN_LIMIT_EN undefined: no counter, scan unbounded except address-wrap fault.
// STRUCTURE
//  Package definitions: STATE (CORE_S, BRANCH_S, CACHE_LOAD_S), BYTE, OP_LOOP_OPEN=8'h5B,
//   OP_LOOP_CLOSE=8'h5D, scanner FSM enum SCAN_ST.
//  One sub-module: bracket_depth_counter (inc/dec/clear, flags zero and overflow).
// TESTING
//  fwd, start_pc=10, mem[11..13]="+-]" -> 3 fetches, done pulse, target_pc=13, state_out=CORE_S 1 cycle.
//  fwd nested, mem[11..15]="[[]]]" -> depth 1,2,3,2,1,0; target_pc=15, no err.
//  back, start_pc=20, mem[19]='>', mem[18]='[' -> fetches 19,18; target_pc=18.
//  fwd from 16'hFFFE, mem[16'hFFFF]='+' -> err=1, done never asserted, state_out=CORE_S.
//  state_in forced to CORE_S mid-fetch -> imem_req=0 next cycle, FSM IDLE, done=0, err=0.
//  rst_n low during FETCH with ack pending -> imem_req=0 same cycle; SCAN_LIMIT_EN, SCAN_MAX=4, no match -> err.

Source files
------------

// File: rtl/bracket_scanner_pkg.sv
// Shared types and opcodes for the bracket scanner: core state encoding,
// bracket opcodes, the scanner FSM encoding and opcode classification helpers.
package bracket_scanner_pkg;

   localparam int STATE_W = 2;
   localparam int BYTE_W  = 8;

   typedef enum logic [STATE_W-1:0] {
      CORE_S       = 2'd0,
      BRANCH_S     = 2'd1,
      CACHE_LOAD_S = 2'd2
   } state_t;

   typedef logic [BYTE_W-1:0] byte_t;

   localparam byte_t OP_LOOP_OPEN  = 8'h5B;
   localparam byte_t OP_LOOP_CLOSE = 8'h5D;

   typedef enum logic [1:0] {
      SC_IDLE  = 2'd0,
      SC_FETCH = 2'd1,
      SC_DONE  = 2'd2,
      SC_FAULT = 2'd3
   } scan_st_t;

   // Backward scans swap the roles of the two brackets.
   function automatic logic is_deeper(input logic back, input byte_t op);
      return back ? (op == OP_LOOP_CLOSE) : (op == OP_LOOP_OPEN);
   endfunction

   function automatic logic is_shallower(input logic back, input byte_t op);
      return back ? (op == OP_LOOP_OPEN) : (op == OP_LOOP_CLOSE);
   endfunction

endpackage

// File: rtl/bracket_depth_counter.sv
// Bracket nesting-depth counter. Clear together with inc loads 1; zero_o reports
// the depth after this cycle's update, ovf_o flags an increment at all-ones.
module bracket_depth_counter #(
   parameter int W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic zero_o,
   output logic ovf_o
);

   logic [W-1:0] depth_q, depth_d;

   always_comb begin
      depth_d = depth_q;
      ovf_o   = inc_i && !clr_i && (&depth_q);
      if (clr_i) begin
         depth_d = inc_i ? W'(1) : '0;
      end else if (inc_i && !ovf_o) begin
         depth_d = depth_q + 1'b1;
      end else if (dec_i && (depth_q != '0)) begin
         depth_d = depth_q - 1'b1;
      end
      zero_o = (depth_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) depth_q <= '0;
      else        depth_q <= depth_d;
   end

endmodule

// File: rtl/bracket_scanner.sv
// Scans instruction memory for the bracket matching a taken branch and reports its pc.
// Define SCAN_LIMIT_EN to bound each scan to SCAN_MAX fetches.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   SC_IDLE  | mirror state_in (registered); wait for CACHE_LOAD_S
//   SC_FETCH | own imem port; fetch pc, track depth (gap_q = idle cycle)
//   SC_DONE  | match found: done pulse, hand back with CORE_S
//   SC_FAULT | unmatched/overflow/budget: set sticky err, hand back CORE_S
import bracket_scanner_pkg::*;

module bracket_scanner #(
   parameter int ADDR_W  = 16,
   parameter int DEPTH_W = 8
`ifdef SCAN_LIMIT_EN
   ,
   parameter int SCAN_MAX = 4096
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [STATE_W-1:0] state_in,
   input  logic [ADDR_W-1:0]  start_pc,
   input  logic               dir_back,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [BYTE_W-1:0]  imem_data,
   output logic [STATE_W-1:0] state_out,
   output logic [ADDR_W-1:0]  target_pc,
   output logic               done,
   output logic               err
);

   scan_st_t           st_q, st_d;
   logic [ADDR_W-1:0]  pc_q, pc_d, tgt_q, tgt_d;
   logic               dir_q, dir_d, err_q, err_d, gap_q, gap_d;
   logic [STATE_W-1:0] sin_q;
   logic               start_trig, ack_ok, start_wrap, pc_wrap, limit_hit;
   logic               depth_inc, depth_dec, depth_zero, depth_ovf;

   assign start_trig = (st_q == SC_IDLE) && (state_in == CACHE_LOAD_S);
   assign ack_ok     = (st_q == SC_FETCH) && !gap_q && imem_ack && (state_in == CACHE_LOAD_S);
   assign start_wrap = dir_back ? (start_pc == '0) : (&start_pc);
   assign pc_wrap    = dir_q ? (pc_q == '0) : (&pc_q);
   assign depth_inc  = start_trig || (ack_ok && is_deeper(dir_q, imem_data));
   assign depth_dec  = ack_ok && is_shallower(dir_q, imem_data);

   bracket_depth_counter #(.W(DEPTH_W)) u_depth (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (start_trig),
      .inc_i  (depth_inc),
      .dec_i  (depth_dec),
      .zero_o (depth_zero),
      .ovf_o  (depth_ovf)
   );

`ifdef SCAN_LIMIT_EN
   localparam int CNT_W = ($clog2(SCAN_MAX + 1) > 12) ? $clog2(SCAN_MAX + 1) : 12;
   logic [CNT_W-1:0] scan_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          scan_cnt_q <= '0;
      else if (start_trig) scan_cnt_q <= '0;
      else if (ack_ok)     scan_cnt_q <= scan_cnt_q + 1'b1;
   end

   assign limit_hit = (scan_cnt_q == CNT_W'(SCAN_MAX - 1));
`else
   assign limit_hit = 1'b0;
`endif

   assign imem_req  = (st_q == SC_FETCH) && !gap_q;
   assign imem_addr = pc_q;
   assign target_pc = tgt_q;
   assign done      = (st_q == SC_DONE);
   assign err       = err_q;

   always_comb begin
      st_d      = st_q;
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      dir_d     = dir_q;
      err_d     = err_q;
      gap_d     = 1'b0;
      state_out = CORE_S;
      case (st_q)
         SC_IDLE: begin
            state_out = sin_q;
            if (start_trig) begin
               dir_d = dir_back;
               if (start_wrap) begin
                  err_d = 1'b1;
                  st_d  = SC_FAULT;
               end else begin
                  pc_d = dir_back ? start_pc - 1'b1 : start_pc + 1'b1;
                  st_d = SC_FETCH;
               end
            end
         end
         SC_FETCH: begin
            state_out = CACHE_LOAD_S;
            // Abort wins over a same-cycle ack: the state unit has moved on.
            if (state_in != CACHE_LOAD_S) begin
               st_d = SC_IDLE;
            end else if (ack_ok) begin
               if (depth_ovf) begin
                  err_d = 1'b1;
                  st_d  = SC_FAULT;
               end else if (depth_zero) begin
                  tgt_d = pc_q;
                  st_d  = SC_DONE;
               end else if (limit_hit || pc_wrap) begin
                  err_d = 1'b1;
                  st_d  = SC_FAULT;
               end else begin
                  pc_d  = dir_q ? pc_q - 1'b1 : pc_q + 1'b1;
                  gap_d = 1'b1;
               end
            end
         end
         SC_DONE:  st_d = SC_IDLE;
         SC_FAULT: st_d = SC_IDLE;
         default:  st_d = SC_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= SC_IDLE;
         pc_q  <= '0;
         tgt_q <= '0;
         dir_q <= 1'b0;
         err_q <= 1'b0;
         gap_q <= 1'b0;
         sin_q <= CORE_S;
      end else begin
         st_q  <= st_d;
         pc_q  <= pc_d;
         tgt_q <= tgt_d;
         dir_q <= dir_d;
         err_q <= err_d;
         gap_q <= gap_d;
         sin_q <= state_in;
      end
   end

endmodule
